// File: rtl/game_pkg.sv
// Shared game-world definitions: gap-bus field layout, initial pipe layout
// and the scene encodings used by the controller and the view.
package game_pkg;

    localparam int GAP_W      = 24;
    localparam int POS_LSB    = 16;
    localparam int MAX_LSB    = 8;
    localparam int MIN_LSB    = 0;
    localparam int N_PIPE_DEF = 3;

    localparam int         INIT_STEP = 20;
    localparam logic [7:0] INIT_MAX  = 8'd30;
    localparam logic [7:0] INIT_MIN  = 8'd20;

    typedef enum logic [1:0] {
        SCENE_IDLE    = 2'd0,
        SCENE_PLAYING = 2'd1,
        SCENE_OVER    = 2'd2
    } scene_e;

    // Field order matches the bus slot: {position, max_bnd, min_bnd}
    typedef struct packed {
        logic [7:0] pos;
        logic [7:0] max_bnd;
        logic [7:0] min_bnd;
    } gap_t;

    // Starting slot k of an n-pipe field; the 3-pipe layout is hand-tuned.
    function automatic gap_t init_slot(input int n, input int k);
        gap_t g;
        g = '{pos: 8'(INIT_STEP * (n - k)), max_bnd: INIT_MAX, min_bnd: INIT_MIN};
        if (n == 3) begin
            case (k)
                1:       g = '{pos: 8'd40, max_bnd: 8'd25, min_bnd: 8'd15};
                0:       g = '{pos: 8'd60, max_bnd: 8'd35, min_bnd: 8'd25};
                default: ;
            endcase
        end
        return g;
    endfunction

endpackage

// File: rtl/pipe_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), free-running out of reset.
module pipe_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out <= seed;
        else     out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
    end

endmodule

// File: rtl/pipe_field.sv
// Pipe obstacle field: scrolls and respawns N_PIPE gap slots, detects
// bird collisions and counts passed pipes.
module pipe_field
    import game_pkg::*;
#(
    parameter int         N_PIPE     = N_PIPE_DEF,
    parameter int         SPACING    = 20,
    parameter int         GAP        = 10,
    parameter int         SCROLL_DIV = 4,
    parameter logic [7:0] LFSR_SEED  = 8'hA5,
    parameter int         BIRD_COL   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              n_row,
    input  logic [7:0]              n_col,
    input  logic                    run,
    input  logic                    start,
    input  logic [7:0]              altitude,
    output logic [GAP_W*N_PIPE-1:0] gaps,
    output logic                    collide,
    output logic [7:0]              score,
    output logic                    passed
);

    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
    localparam logic [7:0] RESP_POS = 8'(N_PIPE * SPACING);
    localparam logic [7:0] HIT_COL  = 8'(BIRD_COL + 6);

    typedef gap_t [N_PIPE-1:0] field_t;

    function automatic field_t init_field();
        field_t f;
        for (int k = 0; k < N_PIPE; k++) f[k] = init_slot(N_PIPE, k);
        return f;
    endfunction

    localparam field_t INIT_FIELD = init_field();

    field_t            slot_q, slot_d;
    logic [DIV_W-1:0]  div_q;
    logic [7:0]        lfsr;
    logic [N_PIPE-1:0] resp, hit;
    logic [8:0]        row9, bird_row, m_raw, m_sel;
    gap_t              rsp_gap;
    logic              advance, step, ground;
    logic              unused_bits;

    pipe_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .out  (lfsr)
    );

    assign unused_bits = ^{n_col, lfsr[7:6]};

    assign advance  = run & ~collide;
    assign step     = advance && (div_q == DIV_LAST);
    assign row9     = {1'b0, n_row};
    assign bird_row = row9 - {1'b0, altitude};
    assign ground   = (altitude == 8'd0) || (altitude >= n_row);

    // Respawn bounds are shared: every slot respawning this step sees the same draw
    always_comb begin
        m_raw = 9'd2 + {3'b000, lfsr[5:0]};
        m_sel = m_raw;
        if (m_raw + 9'(GAP) > row9 - 9'd2) m_sel = row9 - 9'd2 - 9'(GAP);
        if (row9 < 9'(GAP + 4))            m_sel = 9'd2;
        rsp_gap = '{pos: RESP_POS, max_bnd: 8'(m_sel + 9'(GAP)), min_bnd: m_sel[7:0]};
    end

    for (genvar i = 0; i < N_PIPE; i++) begin : g_slot
        assign resp[i]   = (slot_q[i].pos == 8'd0);
        assign slot_d[i] = resp[i] ? rsp_gap
                                   : {slot_q[i].pos - 8'd1, slot_q[i].max_bnd, slot_q[i].min_bnd};
        assign hit[i]    = (slot_q[i].pos <= HIT_COL) &&
                           ((bird_row <= {1'b0, slot_q[i].min_bnd}) ||
                            (bird_row >= {1'b0, slot_q[i].max_bnd}));
    end

    assign gaps = slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= INIT_FIELD;
            div_q   <= '0;
            score   <= 8'd0;
            collide <= 1'b0;
            passed  <= 1'b0;
        end else if (start) begin
            slot_q  <= INIT_FIELD;
            div_q   <= '0;
            score   <= 8'd0;
            collide <= 1'b0;
            passed  <= 1'b0;
        end else begin
            passed <= 1'b0;
            if (run && (ground || (|hit))) collide <= 1'b1;
            if (advance) begin
                div_q <= step ? '0 : div_q + DIV_W'(1);
                if (step) begin
                    slot_q <= slot_d;
                    // Simultaneous respawns still score a single point
                    if (|resp) begin
                        passed <= 1'b1;
                        if (score != 8'hFF) score <= score + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_field.sv
// Directed bench for pipe_field: vector table for scrolling/collision plus
// hand sequences for respawn bounds, start/step priority and saturation.
module tb_pipe_field;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  n_row, n_col, altitude, n_row2, altitude2;
    logic        run, start, run2, start2;
    logic [71:0] gaps;
    logic [23:0] gaps2;
    logic        collide, passed, collide2, passed2;
    logic [7:0]  score, score2;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [71:0] INIT_EXP = {8'd20, 8'd30, 8'd20, 8'd40, 8'd25, 8'd15, 8'd60, 8'd35, 8'd25};

    pipe_field u_dut (
        .clk(clk), .rst(rst), .n_row(n_row), .n_col(n_col), .run(run), .start(start),
        .altitude(altitude), .gaps(gaps), .collide(collide), .score(score), .passed(passed)
    );

    pipe_field #(.N_PIPE(1), .SPACING(1), .GAP(40), .SCROLL_DIV(1)) u_sat (
        .clk(clk), .rst(rst), .n_row(n_row2), .n_col(n_col), .run(run2), .start(start2),
        .altitude(altitude2), .gaps(gaps2), .collide(collide2), .score(score2), .passed(passed2)
    );

    always #5 clk = ~clk;

    // Reference LFSR; lfsr_prev holds the value seen during the previous cycle
    logic [7:0] m_lfsr, lfsr_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr    <= 8'hA5;
            lfsr_prev <= 8'hA5;
        end else begin
            m_lfsr    <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            lfsr_prev <= m_lfsr;
        end
    end

    typedef struct {
        int         cyc;
        logic       run, start;
        logic [7:0] alt;
        logic [7:0] p2, p1, p0;
        logic       col;
        logic [7:0] sc;
        logic       ps;
        logic       init;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] slot(input int i);
        return gaps[24*i +: 24];
    endfunction

    initial begin
        n_row = 8'd40; n_col = 8'd80; altitude = 8'd15; run = 1'b0; start = 1'b0;
        n_row2 = 8'd40; altitude2 = 8'd15; run2 = 1'b0; start2 = 1'b0;

        #2 rst = 1'b1;
        #1;
        check("reset_gaps", gaps, INIT_EXP);
        check("reset_score", score, 0);
        check("reset_collide", collide, 0);
        check("reset_passed", passed, 0);
        @(negedge clk) rst = 1'b0;

        //             cyc run st alt   p2  p1  p0 col sc ps init
        tbl.push_back('{ 1, 1, 1, 15,  20, 40, 60, 0, 0, 0, 1});
        tbl.push_back('{47, 1, 0, 15,   9, 29, 49, 0, 0, 0, 0});
        tbl.push_back('{ 1, 1, 0, 15,   8, 28, 48, 0, 0, 0, 0});
        tbl.push_back('{32, 1, 0, 15,   0, 20, 40, 0, 0, 0, 0});
        tbl.push_back('{ 4, 1, 0, 15,  60, 19, 39, 0, 1, 1, 0});
        tbl.push_back('{44, 1, 0, 15,  49,  8, 28, 0, 1, 0, 0});
        tbl.push_back('{ 1, 1, 0, 15,  49,  8, 28, 1, 1, 0, 0});
        tbl.push_back('{20, 1, 0, 15,  49,  8, 28, 1, 1, 0, 0});
        tbl.push_back('{ 1, 1, 1, 15,  20, 40, 60, 0, 0, 0, 1});
        tbl.push_back('{ 1, 1, 0,  0,  20, 40, 60, 1, 0, 0, 1});
        tbl.push_back('{ 1, 0, 1,  0,  20, 40, 60, 0, 0, 0, 1});
        tbl.push_back('{10, 0, 0,  0,  20, 40, 60, 0, 0, 0, 1});
        tbl.push_back('{ 3, 1, 0, 39,  20, 40, 60, 0, 0, 0, 1});
        tbl.push_back('{ 1, 1, 0, 40,  19, 39, 59, 1, 0, 0, 0});

        foreach (tbl[v]) begin
            run = tbl[v].run; start = tbl[v].start; altitude = tbl[v].alt;
            repeat (tbl[v].cyc) tick();
            start = 1'b0;
            check($sformatf("v%0d_pos2", v), slot(2) >> 16, tbl[v].p2);
            check($sformatf("v%0d_pos1", v), slot(1) >> 16, tbl[v].p1);
            check($sformatf("v%0d_pos0", v), slot(0) >> 16, tbl[v].p0);
            check($sformatf("v%0d_collide", v), collide, tbl[v].col);
            check($sformatf("v%0d_score", v), score, tbl[v].sc);
            check($sformatf("v%0d_passed", v), passed, tbl[v].ps);
            if (tbl[v].init) check($sformatf("v%0d_gaps", v), gaps, INIT_EXP);
        end

        // Respawn bounds across the clamp boundaries, slot2 respawning at step 21
        begin
            int nrs[4] = '{13, 14, 40, 200};
            foreach (nrs[j]) begin
                int nr, m;
                nr = nrs[j];
                n_row = 8'd40; altitude = 8'd15; run = 1'b1; start = 1'b1;
                tick();
                start = 1'b0;
                repeat (83) tick();
                n_row = 8'(nr);
                altitude = (nr >= 30) ? 8'(nr - 25) : 8'd7;
                tick();
                m = 2 + int'(lfsr_prev[5:0]);
                if (m + 10 > nr - 2) m = nr - 12;
                if (nr < 14) m = 2;
                check($sformatf("resp%0d_pos", nr), slot(2) >> 16, 60);
                check($sformatf("resp%0d_min", nr), slot(2) & 24'hFF, m);
                check($sformatf("resp%0d_max", nr), (slot(2) >> 8) & 24'hFF, m + 10);
                check($sformatf("resp%0d_pos1", nr), slot(1) >> 16, 19);
                check($sformatf("resp%0d_score", nr), score, 1);
                check($sformatf("resp%0d_passed", nr), passed, 1);
                check($sformatf("resp%0d_collide", nr), collide, (nr < 30));
                n_row = 8'd40; altitude = 8'd15;
                tick();
                check($sformatf("resp%0d_passed_end", nr), passed, 0);
                check($sformatf("resp%0d_score_hold", nr), score, 1);
            end
        end

        // Start coinciding with a scroll step: layout reload wins
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_step_gaps", gaps, INIT_EXP);
        check("start_step_score", score, 0);
        check("start_step_passed", passed, 0);
        run = 1'b0;

        // Saturation on the single-pipe instance (step every cycle)
        begin
            int cnt;
            bit seen;
            cnt = 0;
            seen = 1'b0;
            run2 = 1'b1; start2 = 1'b1;
            tick();
            start2 = 1'b0;
            for (int c = 0; c < 2000 && score2 != 8'd255; c++) begin
                tick();
                if (passed2) cnt++;
            end
            check("sat_score_reached", score2, 255);
            check("sat_pulse_count", cnt, 255);
            check("sat_collide", collide2, 0);
            check("sat_bounds", gaps2[15:0], {8'd42, 8'd2});
            for (int c = 0; c < 5 && !seen; c++) begin
                tick();
                if (passed2) seen = 1'b1;
            end
            check("sat_extra_passed", seen, 1);
            check("sat_score_hold", score2, 255);
        end

        // Asynchronous reset mid-run, between clock edges
        #2 rst = 1'b1;
        #1;
        check("async_rst_score", score2, 0);
        check("async_rst_gaps", gaps, INIT_EXP);
        check("async_rst_slot", gaps2, {8'd20, 8'd30, 8'd20});
        @(negedge clk) rst = 1'b0;
        run2 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
